// File: rtl/vec_stream_sched.sv
`default_nettype none
// ============================================================================
// vec_stream_sched : job sequencer gating the FIFO stream into vec_cat and
// tagging emitted vectors REF/CMP. Optional macro: VEC_SCHED_STALL_CNT_EN.
// Revision: 1.0
// ============================================================================
module vec_stream_sched #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int CNT_WIDTH    = 16,
  parameter int VEC_ID_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_start,
  input  logic [CNT_WIDTH-1:0]    cfg_ref_no,
  input  logic [CNT_WIDTH-1:0]    cfg_cmp_no,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic                    cfg_err,
  input  logic [BUS_WIDTH-1:0]    s_vector,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [BUS_WIDTH-1:0]    m_vector,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  input  logic [VEC_ID_WIDTH-1:0] dn_vec_id,
  input  logic                    dn_valid,
  input  logic                    dn_ready,
  input  logic                    dn_last,
  output logic                    o_is_ref,
  output logic [CNT_WIDTH:0]      o_vec_idx,
  output logic [31:0]             stall_cycles
);

  localparam int c_bus_bytes = BUS_WIDTH / 8;
  localparam int c_vec_bytes = VECTOR_WIDTH / 8;
  localparam int c_shift     = $clog2(c_bus_bytes);
  localparam int c_tot_w     = CNT_WIDTH + 1;
  // Product of vector count and vector bytes, plus one bit for the round-up add.
  localparam int c_byte_w    = c_tot_w + $clog2(c_vec_bytes + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  ref_no_q, ref_no_d;
  logic [c_tot_w-1:0]    total_q, total_d;
  logic [c_byte_w-1:0]   beat_total_q, beat_total_d;
  logic [c_byte_w-1:0]   beat_cnt_q, beat_cnt_d;
  logic [c_tot_w-1:0]    out_cnt_q, out_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  run_w, track_w, accept_w, up_hs_w, dn_hs_w, last_beat_w;
  logic [c_tot_w-1:0]    start_total_w;
  logic [c_byte_w-1:0]   bytes_w, beats_w;

  assign run_w         = (state_q == S_RUN);
  assign track_w       = run_w || (state_q == S_DRAIN);
  assign accept_w      = (state_q == S_IDLE) && cfg_start && !busy_q;
  assign start_total_w = {1'b0, cfg_ref_no} + {1'b0, cfg_cmp_no};
  assign bytes_w       = c_byte_w'(total_q) * c_byte_w'(c_vec_bytes);
  assign beats_w       = (bytes_w + c_byte_w'(c_bus_bytes - 1)) >> c_shift;
  assign last_beat_w   = (beat_cnt_q == beat_total_q - c_byte_w'(1));
  assign up_hs_w       = run_w && s_valid && m_ready;
  assign dn_hs_w       = track_w && dn_valid && dn_ready;

  assign m_vector  = s_vector;
  assign m_valid   = run_w && s_valid;
  assign s_ready   = run_w && m_ready;
  assign m_last    = m_valid && last_beat_w;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign o_vec_idx = out_cnt_q;
  assign o_is_ref  = track_w && (out_cnt_q < {1'b0, ref_no_q});

  always_comb begin
    state_d      = state_q;
    ref_no_d     = ref_no_q;
    total_d      = total_q;
    beat_total_d = beat_total_q;
    beat_cnt_d   = beat_cnt_q;
    out_cnt_d    = out_cnt_q;
    busy_d       = busy_q;
    done_d       = (state_q == S_DONE);
    err_d        = err_q;

    if (done_q) busy_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_w) begin
          ref_no_d   = cfg_ref_no;
          total_d    = start_total_w;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          beat_cnt_d = '0;
          out_cnt_d  = '0;
          state_d    = (start_total_w == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        beat_total_d = beats_w;
        state_d      = S_RUN;
      end
      S_RUN: begin
        if (up_hs_w) begin
          beat_cnt_d = beat_cnt_q + c_byte_w'(1);
          if (last_beat_w) state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    // Downstream monitor; runs alongside the input beat counter.
    if (dn_hs_w) begin
      out_cnt_d = out_cnt_q + c_tot_w'(1);
      if (dn_vec_id != out_cnt_q[VEC_ID_WIDTH-1:0]) err_d = 1'b1;
      if (dn_last) begin
        if (out_cnt_q != total_q - c_tot_w'(1)) err_d = 1'b1;
        if (run_w) err_d = 1'b1;
        else       state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      ref_no_q     <= '0;
      total_q      <= '0;
      beat_total_q <= '0;
      beat_cnt_q   <= '0;
      out_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ref_no_q     <= ref_no_d;
      total_q      <= total_d;
      beat_total_q <= beat_total_d;
      beat_cnt_q   <= beat_cnt_d;
      out_cnt_q    <= out_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef VEC_SCHED_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept_w)
      stall_d = '0;
    else if (run_w && !(m_valid && m_ready) && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_stream_sched.sv
`default_nettype none
// tb_vec_stream_sched: randomized jobs checked against a job-level model
// (beat count from byte arithmetic, phase timeline, expected error flag).
module tb_vec_stream_sched;
  localparam int BUS_WIDTH    = 128;
  localparam int VECTOR_WIDTH = 920;
  localparam int CNT_WIDTH    = 16;
  localparam int VEC_ID_WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    cfg_start;
  logic [CNT_WIDTH-1:0]    cfg_ref_no, cfg_cmp_no;
  logic                    cfg_busy, cfg_done, cfg_err;
  logic [BUS_WIDTH-1:0]    s_vector, m_vector;
  logic                    s_valid, s_ready, m_valid, m_last, m_ready;
  logic [VEC_ID_WIDTH-1:0] dn_vec_id;
  logic                    dn_valid, dn_ready, dn_last;
  logic                    o_is_ref;
  logic [CNT_WIDTH:0]      o_vec_idx;
  logic [31:0]             stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  vec_stream_sched #(
    .BUS_WIDTH(BUS_WIDTH), .VECTOR_WIDTH(VECTOR_WIDTH),
    .CNT_WIDTH(CNT_WIDTH), .VEC_ID_WIDTH(VEC_ID_WIDTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_start(cfg_start), .cfg_ref_no(cfg_ref_no), .cfg_cmp_no(cfg_cmp_no),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .s_vector(s_vector), .s_valid(s_valid), .s_ready(s_ready),
    .m_vector(m_vector), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .dn_vec_id(dn_vec_id), .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_last(dn_last),
    .o_is_ref(o_is_ref), .o_vec_idx(o_vec_idx), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Phases: 0 CALC, 1 RUN, 2 DRAIN, 3 DONE state, 4 done pulse, 5 back to idle.
  // inject: 0 none, 1 premature dn_last in RUN, 2 one corrupted dn_vec_id.
  task automatic run_job(input int r, input int c, input int vpct, input int rpct,
                         input int inject, input int abort_at);
    int n, exp_beats, phase, nphase, outc, stall, dut_beats, dut_lasts, cyc;
    logic exp_err, injected, trk, run, dv, dl;
    logic [7:0] id;
    n         = r + c;
    exp_beats = (n * (VECTOR_WIDTH / 8) + BUS_WIDTH / 8 - 1) / (BUS_WIDTH / 8);
    outc = 0; stall = 0; dut_beats = 0; dut_lasts = 0;
    exp_err = 1'b0; injected = 1'b0;

    @(negedge clk);
    cfg_start = 1'b1; cfg_ref_no = 16'(r); cfg_cmp_no = 16'(c);
    s_valid = 1'b1; m_ready = 1'b1; dn_valid = 1'b0; dn_last = 1'b0;
    #1;
    check_eq("idle_s_ready", s_ready, 0);
    check_eq("idle_busy", cfg_busy, 0);
    phase = (n == 0) ? 3 : 0;

    for (cyc = 0; ; cyc++) begin
      @(negedge clk);
      if (abort_at != 0 && cyc == abort_at) begin
        rstn = 1'b0; cfg_start = 1'b0; s_valid = 1'b1; m_ready = 1'b1; dn_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_eq("rst_busy", cfg_busy, 0);
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_done", cfg_done, 0);
        check_eq("rst_vec_idx", o_vec_idx, 0);
        check_eq("rst_stall", stall_cycles, 0);
        return;
      end
      if (cyc > 4000) begin
        check_eq("timeout_phase", phase, 5);
        return;
      end
      cfg_start  = (phase < 5) && ($urandom_range(7) == 0);
      cfg_ref_no = 16'($urandom);
      cfg_cmp_no = 16'($urandom);
      s_valid    = ($urandom_range(99) < vpct);
      m_ready    = ($urandom_range(99) < rpct);
      s_vector   = {$urandom, $urandom, $urandom, $urandom};
      trk = (phase == 1) || (phase == 2);
      run = (phase == 1);
      dv = 1'b0; dl = 1'b0; id = 8'($urandom);
      dn_ready = ($urandom_range(3) != 0);
      // The final vector is held back until every input beat has passed.
      if (trk && outc < n && (outc < n - 1 || phase == 2)) dv = ($urandom_range(3) != 0);
      if (dv) begin
        id = 8'(outc);
        dl = (outc == n - 1);
        if (inject == 1 && !injected && run && dn_ready) begin dl = 1'b1; injected = 1'b1; end
        if (inject == 2 && !injected && dn_ready) begin id = id ^ 8'h5a; injected = 1'b1; end
      end
      dn_valid = dv; dn_last = dl; dn_vec_id = id;
      #1;
      check_eq("m_valid", m_valid, run && s_valid);
      check_eq("s_ready", s_ready, run && m_ready);
      check_eq("m_vector", m_vector, s_vector);
      check_eq("m_last", m_last, run && s_valid && (dut_beats == exp_beats - 1));
      check_eq("cfg_done", cfg_done, phase == 4);
      check_eq("cfg_busy", cfg_busy, phase != 5);
      check_eq("o_is_ref", o_is_ref, trk && (outc < r));
      if (trk) check_eq("o_vec_idx", o_vec_idx, outc);
      if (phase == 5) break;

      if (m_valid && m_ready) begin
        dut_beats++;
        if (m_last) dut_lasts++;
      end
      if (run && !(s_valid && m_ready)) stall++;
      nphase = phase;
      case (phase)
        0: nphase = 1;
        1: if (s_valid && m_ready && dut_beats == exp_beats) nphase = 2;
        3: nphase = 4;
        4: nphase = 5;
        default: ;
      endcase
      if (trk && dv && dn_ready) begin
        if (dl && (run || outc != n - 1)) exp_err = 1'b1;
        if (id != 8'(outc)) exp_err = 1'b1;
        if (dl && phase == 2) nphase = 3;
        outc++;
      end
      phase = nphase;
    end
    cfg_start = 1'b0;
    check_eq("beats", dut_beats, exp_beats);
    check_eq("lasts", dut_lasts, (n > 0) ? 1 : 0);
    check_eq("cfg_err", cfg_err, exp_err);
    check_eq("dn_count", outc, n);
`ifdef VEC_SCHED_STALL_CNT_EN
    check_eq("stall", stall_cycles, stall);
`endif
  endtask

  initial begin
    rstn = 1'b0; cfg_start = 1'b0; cfg_ref_no = '0; cfg_cmp_no = '0;
    s_valid = 1'b1; m_ready = 1'b1; s_vector = {4{32'hA5C3_0F1E}};
    dn_vec_id = '0; dn_valid = 1'b0; dn_ready = 1'b0; dn_last = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_busy", cfg_busy, 0);
    check_eq("reset_done", cfg_done, 0);
    check_eq("reset_err", cfg_err, 0);
    check_eq("reset_s_ready", s_ready, 0);
    check_eq("reset_m_valid", m_valid, 0);
    check_eq("reset_m_last", m_last, 0);
    check_eq("reset_is_ref", o_is_ref, 0);
    check_eq("reset_vec_idx", o_vec_idx, 0);
    check_eq("reset_stall", stall_cycles, 0);
    check_eq("reset_m_vector", m_vector, s_vector);
    rstn = 1'b1;

    run_job(8, 24, 100, 100, 0, 0);
    run_job(1, 0, 100, 100, 0, 0);
    run_job(8, 0, 25, 50, 0, 0);
    run_job(2, 2, 100, 100, 1, 0);
    run_job(0, 0, 100, 100, 0, 0);
    run_job(3, 1, 60, 70, 2, 0);
    run_job(8, 0, 100, 100, 0, 20);
    run_job(1, 0, 100, 100, 0, 0);
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(5), $urandom_range(5), 20 + $urandom_range(80),
              20 + $urandom_range(80), 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
